// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 codes,
// FSM state encoding and access-legality helpers.
package dmem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Latency counter width: holds LATENCY-2 for LATENCY up to 8
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Access size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clear the low address bits that a naturally aligned access cannot use
    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] lo;
        case (size)
            2'b01:   lo = {addr_lo[1], 1'b0};
            2'b10:   lo = 2'b00;
            default: lo = addr_lo;
        endcase
        return lo;
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select plus sign/zero extension from an aligned 32-bit word.
// Little-endian: byte k of the word is raw_word[8k+7:8k].
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw_word,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/half and extend it according to funct3
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        rdata  = 32'h0000_0000;

        case (addr_lo)
            2'b00:   byte_s = raw_word[7:0];
            2'b01:   byte_s = raw_word[15:8];
            2'b10:   byte_s = raw_word[23:16];
            2'b11:   byte_s = raw_word[31:24];
            default: byte_s = 8'h00;
        endcase

        if (addr_lo[1]) begin
            half_s = raw_word[31:16];
        end else begin
            half_s = raw_word[15:0];
        end

        case (funct3)
            F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata = {{16{half_s[15]}}, half_s};
            F3_W:    rdata = raw_word;
            F3_BU:   rdata = {24'h00_0000, byte_s};
            F3_HU:   rdata = {16'h0000, half_s};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory for the RV32I MEM stage with a valid/ready
// request port, LATENCY-cycle response pulse and an error flag.
// Build option: define DMEM_ERR_EN to report misaligned/illegal accesses on
// rsp_err; without it such accesses are force-aligned or turned into no-ops.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

`ifdef DMEM_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam int DEPTH = 1 << ADDR_W;

    // Byte array; intentionally not reset
    logic [7:0] mem [DEPTH];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               accept_s;
    logic               cur_we_s;
    logic [2:0]         cur_f3_s;
    logic [ADDR_W-1:0]  cur_addr_s;
    logic               bad_s;
    logic               err_s;
    logic [ADDR_W-1:0]  eff_addr_s;
    logic [ADDR_W-3:0]  word_idx_s;
    logic [31:0]        raw_word_s;
    logic [31:0]        ld_data_s;
    logic [3:0]         wen_s;
    logic [31:0]        wdata_lanes_s;
    logic               unused_addr_s;

    // Address bits above ADDR_W wrap and are deliberately ignored
    assign unused_addr_s = ^req_addr[31:ADDR_W];

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign accept_s  = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Current request: live inputs while idle (LATENCY==1 resolves on the
    // accept edge), the captured request while waiting
    always_comb begin
        cur_we_s   = we_q;
        cur_f3_s   = f3_q;
        cur_addr_s = addr_q;
        if (state_q == S_IDLE) begin
            cur_we_s   = req_we;
            cur_f3_s   = req_funct3;
            cur_addr_s = req_addr[ADDR_W-1:0];
        end else begin
            cur_we_s   = we_q;
            cur_f3_s   = f3_q;
            cur_addr_s = addr_q;
        end
    end

    // Legality decode and effective (possibly force-aligned) address
    always_comb begin
        bad_s      = 1'b0;
        err_s      = 1'b0;
        eff_addr_s = cur_addr_s;
        if (ERR_EN) begin
            bad_s = is_misaligned(cur_f3_s[1:0], cur_addr_s[1:0]) ||
                    (cur_we_s ? !store_f3_ok(cur_f3_s) : !load_f3_ok(cur_f3_s));
            err_s      = bad_s;
            eff_addr_s = cur_addr_s;
        end else begin
            bad_s      = cur_we_s ? !store_f3_ok(cur_f3_s) : !load_f3_ok(cur_f3_s);
            err_s      = 1'b0;
            eff_addr_s = {cur_addr_s[ADDR_W-1:2], force_align(cur_f3_s[1:0], cur_addr_s[1:0])};
        end
    end

    // Aligned accesses never straddle a word, so one word read covers all lanes
    assign word_idx_s = eff_addr_s[ADDR_W-1:2];
    assign raw_word_s = {mem[{word_idx_s, 2'b11}], mem[{word_idx_s, 2'b10}],
                         mem[{word_idx_s, 2'b01}], mem[{word_idx_s, 2'b00}]};

    dmem_load_align u_load_align (
        .funct3   (cur_f3_s),
        .addr_lo  (eff_addr_s[1:0]),
        .raw_word (raw_word_s),
        .rdata    (ld_data_s)
    );

    // Store lane enables and lane-replicated write data for the accept edge
    always_comb begin
        wen_s         = 4'b0000;
        wdata_lanes_s = req_wdata;
        if (accept_s && cur_we_s && !bad_s) begin
            case (cur_f3_s[1:0])
                2'b00: begin
                    wen_s[eff_addr_s[1:0]] = 1'b1;
                    wdata_lanes_s          = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    if (eff_addr_s[1]) begin
                        wen_s = 4'b1100;
                    end else begin
                        wen_s = 4'b0011;
                    end
                    wdata_lanes_s = {2{req_wdata[15:0]}};
                end
                2'b10:   wen_s = 4'b1111;
                default: wen_s = 4'b0000;
            endcase
        end else begin
            wen_s = 4'b0000;
        end
    end

    // Commit store bytes on the accept edge
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wen_s[k]) begin
                mem[{word_idx_s, 2'(k)}] <= wdata_lanes_s[8*k +: 8];
            end
        end
    end

    // FSM next state, request capture and response data on entry to RESP
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    we_d   = req_we;
                    f3_d   = req_funct3;
                    addr_d = req_addr[ADDR_W-1:0];
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_RESP) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_s;
            rsp_rdata_d = (cur_we_s || bad_s) ? 32'h0000_0000 : ld_data_s;
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // State and response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= {ADDR_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: three instances (LATENCY 1, 3, 4)
// driven from a vector table plus hand-written reset/latency sequences.
module tb_dmem_ctrl;
    import dmem_pkg::*;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd_e;   // expected rdata with error detection
        logic        er_e;   // expected err with error detection
        logic [31:0] rd_n;   // expected rdata without error detection
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    int   n_checks;
    int   n_errors;
    exp_t sb_q [$];
    vec_t tab [33];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_ctrl #(
            .ADDR_W    (12),
            .LATENCY   (g == 0 ? 1 : (g == 1 ? 3 : 4)),
            .INIT_FILE ("")
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we),
            .req_funct3 (req_funct3),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    // One request on instance d; holds req_valid until the response cycle
    // and checks latency, ready profile and response contents
    task automatic run_req(input int d, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_er, input string nm);
        int   lat;
        int   w;
        exp_t e;
        lat = lat_of(d);
        @(negedge clk);
        req_we       = we;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid[d] = 1'b1;
        w = 0;
        while (req_ready[d] !== 1'b1 && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (req_ready[d] !== 1'b1) begin
            check1({nm, "_ready_timeout"}, req_ready[d], 1'b1);
            req_valid[d] = 1'b0;
            return;
        end
        e.rdata = exp_rd;
        e.err   = exp_er;
        e.name  = nm;
        sb_q.push_back(e);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n < lat) begin
                check1({nm, "_early_valid"}, rsp_valid[d], 1'b0);
                check1({nm, "_busy_ready"}, req_ready[d], 1'b0);
            end else if (n == lat) begin
                check1({nm, "_rsp_valid"}, rsp_valid[d], 1'b1);
                check1({nm, "_resp_ready"}, req_ready[d], 1'b0);
                if (rsp_valid[d] === 1'b1) begin
                    e = sb_q.pop_front();
                    check({e.name, "_rdata"}, rsp_rdata[d], e.rdata);
                    check1({e.name, "_err"}, rsp_err[d], e.err);
                end else begin
                    void'(sb_q.pop_front());
                end
                req_valid[d] = 1'b0;
            end else begin
                check1({nm, "_after_valid"}, rsp_valid[d], 1'b0);
                check1({nm, "_after_ready"}, req_ready[d], 1'b1);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        tab[0]  = '{1'b1, F3_W,   32'h0000_0100, 32'h8899_AABB, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tab[1]  = '{1'b0, F3_B,   32'h0000_0101, 32'h0000_0000, 32'hFFFF_FFAA, 1'b0, 32'hFFFF_FFAA};
        tab[2]  = '{1'b0, F3_BU,  32'h0000_0101, 32'h0000_0000, 32'h0000_00AA, 1'b0, 32'h0000_00AA};
        tab[3]  = '{1'b0, F3_H,   32'h0000_0102, 32'h0000_0000, 32'hFFFF_8899, 1'b0, 32'hFFFF_8899};
        tab[4]  = '{1'b0, F3_W,   32'h0000_0100, 32'h0000_0000, 32'h8899_AABB, 1'b0, 32'h8899_AABB};
        tab[5]  = '{1'b0, F3_HU,  32'h0000_0100, 32'h0000_0000, 32'h0000_AABB, 1'b0, 32'h0000_AABB};
        tab[6]  = '{1'b1, F3_W,   32'h0000_0200, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tab[7]  = '{1'b1, F3_H,   32'h0000_0201, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[8]  = '{1'b0, F3_W,   32'h0000_0200, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'hCAFE_1234};
        tab[9]  = '{1'b0, 3'b011, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[10] = '{1'b1, F3_W,   32'h0000_0100, 32'h1122_3344, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tab[11] = '{1'b0, F3_W,   32'h0000_0103, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h1122_3344};
        tab[12] = '{1'b1, 3'b011, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[13] = '{1'b0, F3_W,   32'h0000_0100, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h1122_3344};
        tab[14] = '{1'b1, F3_H,   32'h0000_0102, 32'hFFFF_5566, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tab[15] = '{1'b1, F3_B,   32'h0000_0101, 32'h0000_0077, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tab[16] = '{1'b0, F3_W,   32'h0000_0100, 32'h0000_0000, 32'h5566_7744, 1'b0, 32'h5566_7744};
        tab[17] = '{1'b0, F3_B,   32'h0000_0100, 32'h0000_0000, 32'h0000_0044, 1'b0, 32'h0000_0044};
        tab[18] = '{1'b0, F3_H,   32'h0000_0100, 32'h0000_0000, 32'h0000_7744, 1'b0, 32'h0000_7744};
        tab[19] = '{1'b0, F3_H,   32'h0000_0102, 32'h0000_0000, 32'h0000_5566, 1'b0, 32'h0000_5566};
        tab[20] = '{1'b1, F3_W,   32'hFFFF_FFFC, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tab[21] = '{1'b0, F3_B,   32'h0000_1FFF, 32'h0000_0000, 32'hFFFF_FFA1, 1'b0, 32'hFFFF_FFA1};
        tab[22] = '{1'b0, F3_H,   32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_A1B2, 1'b0, 32'hFFFF_A1B2};
        tab[23] = '{1'b0, F3_W,   32'h0000_0FFC, 32'h0000_0000, 32'hA1B2_C3D4, 1'b0, 32'hA1B2_C3D4};
        tab[24] = '{1'b0, F3_BU,  32'h0000_0FFD, 32'h0000_0000, 32'h0000_00C3, 1'b0, 32'h0000_00C3};
        tab[25] = '{1'b0, F3_H,   32'h0000_0FFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_A1B2};
        tab[26] = '{1'b0, F3_HU,  32'h0000_0103, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_5566};
        tab[27] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[28] = '{1'b0, 3'b111, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[29] = '{1'b1, 3'b100, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[30] = '{1'b0, F3_W,   32'h0000_0100, 32'h0000_0000, 32'h5566_7744, 1'b0, 32'h5566_7744};
        tab[31] = '{1'b1, F3_W,   32'h0000_0101, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tab[32] = '{1'b0, F3_W,   32'h0000_0100, 32'h0000_0000, 32'h5566_7744, 1'b0, 32'hDEAD_BEEF};

        // Reset with a store request pending: nothing accepted, outputs zero
        for (int d = 0; d < 3; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b1;
        end
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h0000_0300;
        req_wdata  = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                check1($sformatf("rst%0d_ready", d), req_ready[d], 1'b0);
                check1($sformatf("rst%0d_valid", d), rsp_valid[d], 1'b0);
                check($sformatf("rst%0d_rdata", d), rsp_rdata[d], 32'h0000_0000);
            end
        end
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            rst_n[d]     = 1'b1;
        end

        // Table-driven vectors on the LATENCY=1 instance
        for (int i = 0; i < 33; i++) begin
            run_req(0, tab[i].we, tab[i].f3, tab[i].addr, tab[i].wdata,
                    ERR_EN ? tab[i].rd_e : tab[i].rd_n,
                    ERR_EN ? tab[i].er_e : 1'b0,
                    $sformatf("v%0d", i));
        end

        // Reset on a live instance with a store held valid: array untouched
        run_req(0, 1'b1, F3_W, 32'h0000_0300, 32'h0102_0304, 32'h0000_0000, 1'b0, "pre_sw");
        run_req(0, 1'b0, F3_W, 32'h0000_0300, 32'h0000_0000, 32'h0102_0304, 1'b0, "pre_lw");
        @(negedge clk);
        rst_n[0]     = 1'b0;
        req_valid[0] = 1'b1;
        req_we       = 1'b1;
        req_funct3   = F3_W;
        req_addr     = 32'h0000_0300;
        req_wdata    = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check1("rst_live_ready", req_ready[0], 1'b0);
            check1("rst_live_valid", rsp_valid[0], 1'b0);
            check("rst_live_rdata", rsp_rdata[0], 32'h0000_0000);
        end
        req_valid[0] = 1'b0;
        rst_n[0]     = 1'b1;
        run_req(0, 1'b0, F3_W, 32'h0000_0300, 32'h0000_0000, 32'h0102_0304, 1'b0, "post_rst_lw");

        // LATENCY=4: four-cycle response, ready low throughout
        run_req(2, 1'b1, F3_W, 32'h0000_0040, 32'h1357_9BDF, 32'h0000_0000, 1'b0, "l4_sw");
        run_req(2, 1'b0, F3_W, 32'h0000_0040, 32'h0000_0000, 32'h1357_9BDF, 1'b0, "l4_lw");
        run_req(2, 1'b0, F3_B, 32'h0000_0043, 32'h0000_0000, 32'h0000_0013, 1'b0, "l4_lb");
        run_req(2, 1'b0, F3_H, 32'h0000_0042, 32'h0000_0000, 32'h0000_1357, 1'b0, "l4_lh");

        // LATENCY=3: reset during WAIT drops the load, store stays committed
        run_req(1, 1'b1, F3_B, 32'h0000_0010, 32'h0000_005A, 32'h0000_0000, 1'b0, "l3_sb");
        @(negedge clk);
        req_we       = 1'b0;
        req_funct3   = F3_W;
        req_addr     = 32'h0000_0010;
        req_wdata    = 32'h0000_0000;
        req_valid[1] = 1'b1;
        check1("l3_lw_ready", req_ready[1], 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check1("l3_wait_ready", req_ready[1], 1'b0);
        rst_n[1] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check1("l3_rst_no_rsp", rsp_valid[1], 1'b0);
        end
        rst_n[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check1("l3_post_no_rsp", rsp_valid[1], 1'b0);
        end
        run_req(1, 1'b0, F3_BU, 32'h0000_0010, 32'h0000_0000, 32'h0000_005A, 1'b0, "l3_lbu");

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised byte-addressed data memory for the RV32I pipeline MEM stage, successor to the single-cycle combinational data memory.
- Adds a valid/ready request handshake, a configurable read latency (LATENCY), and a response channel with an error flag.
- Uses little-endian byte lanes with per-funct3 sign/zero extension.
- Detects misaligned and illegal accesses.
- The pipeline hazard unit stalls MEM while req_ready is low.

Parameters:
ADDR_W, 12, byte-address width actually decoded; depth = 2**ADDR_W bytes; upper address bits ignored (wrap).
LATENCY, 1, cycles from accept edge to rsp_valid; legal 1..8.
INIT_FILE, "", hex image loaded with $readmemh at elaboration when non-empty.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data, lane 0 = bits [7:0]
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned/illegal access, qualified by rsp_valid

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. req_ready=0 while rst_n is low. Memory array is not reset.
- Accept: req_valid && req_ready at a posedge.
  - Capture we, funct3, addr[ADDR_W-1:0] and wdata.
  - A legal store commits to the array on this same edge.
- FSM states:
  - IDLE -> WAIT on accept when LATENCY>1 (counter loads LATENCY-2).
  - IDLE -> RESP on accept when LATENCY==1.
  - WAIT decrements the counter; WAIT -> RESP when counter==0.
  - RESP -> IDLE unconditionally.
  - rsp_valid=1 exactly in RESP, so rsp_valid rises LATENCY cycles after the accept cycle.
  - Throughput is one request per LATENCY+1 cycles.
- Load data is sampled from the array on the edge entering RESP (registered output); rsp_rdata/rsp_err hold until the next RESP, and are zeroed only by reset.
- Load funct3 and extension (little-endian, byte k = addr+k):
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend {b1,b0}.
  - 010 LW: {b3,b2,b1,b0}.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend {b1,b0}.
- Store funct3: 000 SB, 001 SH, 010 SW write 1/2/4 lanes from wdata[7:0] upward.
- Errors: rsp_err=1 and rsp_rdata=0 in RESP, and no array write, for:
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- Address wrap: lane index = (addr+k) mod 2**ADDR_W. Wrap only arises at the top, since aligned accesses never straddle.
- Read-after-write: a load accepted after a store sees the stored data (the store committed at its accept edge).
- Reset mid-operation: an already-accepted store stays committed; a pending load is dropped and no rsp_valid is issued.
- Inputs are ignored when req_ready=0. The requester must hold req_* stable while req_valid is high and not yet accepted.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined: error detection as above.
- Undefined:
  - rsp_err tied 0.
  - Misaligned accesses are force-aligned: half clears addr[0], word clears addr[1:0].
  - Illegal funct3 loads return 0; illegal funct3 stores are no-ops.

Decomposition:
- Shared package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: S_IDLE, S_WAIT, S_RESP.
  - Function for the misalignment check.
- One natural sub-module, dmem_load_align: combinational lane select plus sign/zero extension (funct3, addr[1:0], 32-bit raw word -> rdata). Reusable by a future cache.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0, and no array write.
2. LATENCY=1:
   - SW addr 0x100 data 0x8899AABB.
   - LB 0x101 -> rsp_rdata=0xFFFFFFAA.
   - LBU 0x101 -> 0x000000AA.
   - LH 0x102 -> 0xFFFF8899.
   - LW 0x100 -> 0x8899AABB.
   - Each rsp_valid arrives 1 cycle after accept.
3. LATENCY=4: LW accepted at cycle 10 -> rsp_valid only at cycle 14; req_ready low cycles 11-14, high at 15; req_valid held through this is not re-accepted.
4. DMEM_ERR_EN defined:
   - SH addr 0x201 -> rsp_err=1, and memory at 0x200-0x203 is unchanged (checked by a following LW).
   - LW funct3=011 -> rsp_err=1, rdata=0.
5. DMEM_ERR_EN undefined: LW addr 0x103 after SW 0x100 data 0x11223344 -> 0x11223344, rsp_err=0.
6. Reset mid-op, LATENCY=3:
   - SB 0x10 data 0x5A, then LW 0x10; assert rst_n=0 during WAIT -> no rsp_valid.
   - After release, LBU 0x10 -> 0x0000005A.
